// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART oversampling constants and receiver state type
package uart_pkg;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_TICK   = 4'd7;
    localparam logic [3:0] LAST_TICK  = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word valid/ready handshake between receiver and consumer
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx pad synchronizer chain, resets to the idle-high level
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver; UART_RX_PARITY_EN adds even parity (8E1)
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxclk_en,
    input  logic      rx,
    uart_rx_if.master rx_bus,
    output logic      frame_err,
    output logic      overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic      parity_err
`endif
);

    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic [3:0]           tick_cnt, tick_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                 load_word;
    logic                 stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_nxt;
    logic                 par_hit;
`endif

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_bad_nxt;
`endif
        end
    end

    // Everything below only moves on an oversample tick; without one the frame is frozen.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        load_word = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        par_hit     = 1'b0;
`endif
        if (rxclk_en) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == MID_TICK) begin
                        if (!rx_s) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    tick_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_nxt   = bit_cnt + 4'd1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        par_bad_nxt = ^{shift_reg, rx_s};
                        state_nxt   = STOP;
                    end
                end
`endif
                STOP: begin
                    tick_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == LAST_TICK) begin
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            load_word = !par_bad;
                            par_hit   = par_bad;
`else
                            load_word = 1'b1;
`endif
                            state_nxt = IDLE;
                        end else begin
                            stop_bad  = 1'b1;
                            state_nxt = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Holding register: a new word only wins if the old one is gone or leaving this clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_bus.data  <= '0;
            rx_bus.valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err   <= 1'b0;
`endif
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_hit;
`endif
            if (load_word) begin
                if (!rx_bus.valid || rx_bus.ready) begin
                    rx_bus.data  <= shift_reg;
                    rx_bus.valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_bus.valid && rx_bus.ready) begin
                rx_bus.valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampling UART receiver: 8N1 by default, LSB first, idle-high line.
- Consumes the rxclk_en strobe from the team's baud rate generator, one pulse per 1/16 bit time.
- Deserialises the rx pin into bytes and presents them on a valid/ready output interface.
- Sits between the pad and the uart_transport framing logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9).
- SYNC_STAGES, 2, flops in the rx input synchronizer (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rxclk_en  in  1  16x oversample strobe, one clk wide.
- rx  in  1  asynchronous serial input, idle high.
- data  out  DATA_BITS  received word; held stable while valid=1.
- valid  out  1  data holds an unconsumed word.
- ready  in  1  consumer accepts data when valid&&ready on a clk edge.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- overrun  out  1  one-clk pulse: word completed while holding register occupied and not being consumed.

Behaviour:
- Reset: async, active-high.
  - Sets data=0, valid=0, frame_err=0, overrun=0.
  - FSM=IDLE, tick counter=0, bit counter=0, synchronizer flops=1.
- rx passes through the SYNC_STAGES synchronizer. All decisions use the synchronized value rx_s.
- FSM state and counters advance only on clk edges where rxclk_en=1, except output handshake logic, which runs every clk.
- IDLE: on a tick with rx_s=0, go to START and clear tick_cnt to 0.
- START: tick_cnt increments per tick. At tick_cnt==7 (mid start bit):
  - rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0.
  - rx_s=1 -> IDLE (glitch rejected, no outputs).
- DATA: tick_cnt increments per tick, 4-bit, wraps 15->0. At tick_cnt==15:
  - Shift rx_s into shift register MSB; the LSB arrives first.
  - bit_cnt++.
  - After DATA_BITS samples go to STOP (or PARITY when the option is enabled).
- STOP: at tick_cnt==15, sample rx_s.
  - 1 -> load word, go to IDLE.
  - 0 -> pulse frame_err, discard word, go to BREAK.
- BREAK: stay until a tick with rx_s=1, then IDLE. A held-low line yields one frame_err only.
- Latency: valid rises one clk after the rxclk_en edge that samples a good stop bit.
- Output register:
  - valid clears on valid&&ready.
  - Load while valid=0 -> data updated, valid=1.
  - Load while valid=1 and ready=1 in the same clk -> new word replaces old, valid stays 1, no overrun.
  - Load while valid=1 and ready=0 -> new word dropped, old data retained, overrun pulses 1 clk.
- frame_err and overrun are never asserted in the same clk. A framing error never loads data.
- rxclk_en held low freezes the FSM. rx activity is ignored except by the synchronizer.
- rst asserted mid-frame aborts immediately. The partial word is lost and no pulse is generated.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, sampled at tick_cnt==15.
  - Even parity over the data bits.
  - Extra output port parity_err (1 bit, reset 0): one-clk pulse on mismatch, asserted in the same clk the word would load.
  - A word with a parity mismatch is discarded, i.e. not loaded.
  - The stop check still follows.
  - Frame becomes 8E1.
- Not defined: no PARITY state, no parity_err port; 8N1 only.

Decomposition:
- Package uart_pkg:
  - OVERSAMPLE=16, MID_TICK=7, LAST_TICK=15.
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - Shared with the future uart_tx.
- Sub-module uart_rx_sync: parameterised SYNC_STAGES flop chain, reset value 1.

Test Plan:
Common bench setup: rxclk_en pulses every 4th clk (1 bit = 64 clk), ready=1 unless stated.
- Frame 0xA5, 8N1 -> data=0xA5, valid=1 for exactly 1 clk after the stop-bit sample. No frame_err or overrun.
- rx low for 3 ticks (12 clk) then high -> FSM returns to IDLE, valid/frame_err stay 0.
- Frame 0x3C with stop bit 0 and line held low for 5 bit times -> one frame_err pulse, valid=0. Then a clean 0x81 -> data=0x81.
- ready=0, frames 0x11 then 0x22 back-to-back -> overrun pulse at the second stop, data=0x11, valid=1. Raise ready -> valid drops next clk.
- Assert rst during bit 4 of a 0xFF frame -> all outputs 0 asynchronously. After release a clean 0x5A is received correctly.
- Parity variant (UART_RX_PARITY_EN): 0x07 with parity bit 0 -> parity_err pulse, no valid. With parity bit 1 -> data=0x07, valid=1.
